// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) engine.
// One iteration per clock; HI/LO only update on the edge that enters FIN.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;

  typedef struct packed {
    logic neg_q;
    logic neg_r;
  } div_sign_t;

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic          last;
  logic          accept;

  // Booth accumulator: sign-extended upper half (WIDTH+1) plus multiplier half
  logic [WIDTH:0]   mcand;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             booth_q;
  logic [WIDTH:0]   m_sum, m_hi_n;
  logic [WIDTH-1:0] m_lo_n;

  logic [WIDTH-1:0] rem, quo, dvs;
  div_sign_t        dsign;
  logic [WIDTH:0]   d_shift;
  logic             d_ge;
  logic [WIDTH-1:0] d_rem_n, d_quo_n;
  logic [WIDTH-1:0] d_q_fix, d_r_fix;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign last   = (cnt == CW'(WIDTH-1));
  assign accept = start && (state == IDLE || state == FIN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        state_nxt = IDLE;
        if (start) begin
          if (!op)        state_nxt = MULT;
          else if (b != 0) state_nxt = DIV;
          else             state_nxt = FIN;
        end
      end
      MULT:    if (last) state_nxt = FIN;
      DIV:     if (last) state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end

  // One Booth step: add/sub on the pair {lsb, q-1}, then arithmetic shift right
  always_comb begin
    m_sum = acc_hi;
    case ({acc_lo[0], booth_q})
      2'b01:   m_sum = acc_hi + mcand;
      2'b10:   m_sum = acc_hi - mcand;
      default: m_sum = acc_hi;
    endcase
    m_hi_n = {m_sum[WIDTH], m_sum[WIDTH:1]};
    m_lo_n = {m_sum[0], acc_lo[WIDTH-1:1]};
  end

  // One restoring step; the partial remainder always stays below dvs, so
  // the WIDTH-bit subtraction is exact whenever the compare succeeds.
  always_comb begin
    d_shift = {rem, quo[WIDTH-1]};
    d_ge    = (d_shift >= {1'b0, dvs});
    d_rem_n = d_ge ? (d_shift[WIDTH-1:0] - dvs) : d_shift[WIDTH-1:0];
    d_quo_n = {quo[WIDTH-2:0], d_ge};
    d_q_fix = dsign.neg_q ? -d_quo_n : d_quo_n;
    d_r_fix = dsign.neg_r ? -d_rem_n : d_rem_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      mcand    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      booth_q  <= 1'b0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      dsign    <= '0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt == MULT) || (state_nxt == DIV);
      done     <= (state_nxt == FIN);
      div_zero <= 1'b0;
      if (accept) begin
        cnt         <= '0;
        mcand       <= {a[WIDTH-1], a};
        acc_hi      <= '0;
        acc_lo      <= b;
        booth_q     <= 1'b0;
        rem         <= '0;
        quo         <= mag(a);
        dvs         <= mag(b);
        dsign.neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
        dsign.neg_r <= a[WIDTH-1];
        div_zero    <= op && (b == 0);
      end else if (state == MULT) begin
        cnt     <= cnt + CW'(1);
        acc_hi  <= m_hi_n;
        acc_lo  <= m_lo_n;
        booth_q <= acc_lo[0];
        if (last) begin
          hi <= m_hi_n[WIDTH-1:0];
          lo <= m_lo_n;
        end
      end else if (state == DIV) begin
        cnt <= cnt + CW'(1);
        rem <= d_rem_n;
        quo <= d_quo_n;
        if (last) begin
          hi <= d_r_fix;
          lo <= d_q_fix;
        end
      end
    end
  end

endmodule
